// File: rtl/eprisc_uart_tx_sched_pkg.sv
// Shared definitions for the epRISC UART transmit scheduler:
// UART register map, control bit positions, scheduler states and
// the control-word builder used for both send and abort writes.
package eprisc_uart_tx_sched_pkg;

  // UART register addresses on the 16-bit register bus
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_TXD  = 2'd1;
  localparam logic [1:0] ADDR_RXD  = 2'd2;

  // Control register bit positions
  localparam int CTL_SEND = 7;
  localparam int CTL_INT  = 6;
  localparam int CTL_RECV = 5;

  // Scheduler states; ST_IDLE must stay at encoding 0 so reset lands there
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_CTRL = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_POLL    = 3'd5,
    ST_ABORT   = 3'd6,
    ST_DONE    = 3'd7
  } sched_state_t;

  // Control word: upper byte zero, send bit on top of the latched config.
  // The config bits pass through untouched, so the receive enable (bit 5)
  // keeps whatever the requester's config says.
  function automatic logic [15:0] ctrl_word(input logic send, input logic [6:0] cfg);
    logic [15:0] w;
    w           = {9'h000, cfg};
    w[CTL_SEND] = send;
    return w;
  endfunction

endpackage

// File: rtl/eprisc_uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at
// or after iPtr, wrapping around. Produces a one-hot grant, the grant
// index and an any-request flag.
module eprisc_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  iReq,
  input  logic [IDX_W-1:0] iPtr,
  output logic [NREQ-1:0]  oGnt,
  output logic [IDX_W-1:0] oIdx,
  output logic             oAny
);

  // Walk the requesters starting at the pointer; the first hit wins
  always_comb begin
    logic [IDX_W-1:0] cand;
    oIdx = '0;
    oAny = 1'b0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(iPtr) + k) % NREQ);
      if (!oAny && iReq[cand]) begin
        oAny = 1'b1;
        oIdx = cand;
      end
    end
  end

  // One-hot grant decoded from the winning index
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign oGnt[gi] = oAny && (oIdx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/eprisc_uart_tx_sched.sv
// Round-robin scheduler sharing one epRISC UART transmitter among NREQ
// byte requesters. Per granted byte it waits for the UART to be idle,
// writes the TX data register, writes the control register with the send
// bit, then polls until the send bit clears. A poll that stays busy for
// 2**TIMEOUT_W-1 cycles is aborted (send bit cleared) and reported as an
// error to the requester.
module eprisc_uart_tx_sched
  import eprisc_uart_tx_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [NREQ-1:0]   iReqValid,
  input  logic [NREQ*8-1:0] iReqData,
  output logic [NREQ-1:0]   oReqAck,
  output logic [NREQ-1:0]   oReqErr,
  input  logic [6:0]        iCfg,
  output logic              oBusy,
  output logic [1:0]        oAddr,
  output logic [15:0]       oBusData,
  input  logic [15:0]       iBusData,
  output logic              oWrite,
  output logic              oEnable
);

  localparam int IDX_W = $clog2(NREQ);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;       // round-robin start point
  logic [IDX_W-1:0]     gidx_q, gidx_d;     // requester being served
  logic [7:0]           byte_q, byte_d;     // byte latched at grant
  logic [6:0]           cfg_q, cfg_d;       // UART config latched at grant
  logic                 err_q, err_d;       // transfer was aborted
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;       // busy-poll counter
  logic [TIMEOUT_W-1:0] cnt_inc;

  logic [NREQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [7:0]           req_byte_masked [NREQ];
  logic [7:0]           grant_byte;
  logic                 uart_sending;
  logic                 unused_bus_bits;

  // The send bit read back already folds in the UART's own send state,
  // so it is used directly with no resynchronisation.
  assign uart_sending    = iBusData[CTL_SEND];
  assign unused_bus_bits = ^{iBusData[15:8], iBusData[6:0]};
  assign cnt_inc         = cnt_q + TIMEOUT_W'(1);

  eprisc_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .iReq (iReqValid),
    .iPtr (ptr_q),
    .oGnt (arb_gnt),
    .oIdx (arb_idx),
    .oAny (arb_any)
  );

  // AND-OR byte mux driven by the one-hot grant
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_byte_mask
      assign req_byte_masked[gi] = iReqData[8*gi +: 8] & {8{arb_gnt[gi]}};
    end
  endgenerate

  // Combine the masked requester bytes into the granted byte
  always_comb begin
    grant_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      grant_byte = grant_byte | req_byte_masked[k];
    end
  end

  // Next-state logic and UART bus drive; bus is fully zero when not enabled
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    byte_d   = byte_q;
    cfg_d    = cfg_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    oEnable  = 1'b0;
    oWrite   = 1'b0;
    oAddr    = '0;
    oBusData = '0;

    case (state_q)
      ST_IDLE: begin
        // Arbitration only happens here, so a requester re-asserting in
        // the cycle of its own pulse waits behind the others.
        if (arb_any) begin
          gidx_d  = arb_idx;
          byte_d  = grant_byte;
          cfg_d   = iCfg;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_PRE;
        end
      end

      ST_PRE, ST_POLL: begin
        // Read control register; the send bit says whether a frame is live
        oEnable = 1'b1;
        oAddr   = ADDR_CTRL;
        if (!uart_sending) begin
          state_d = (state_q == ST_PRE) ? ST_WR_DATA : ST_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (&cnt_inc) begin
            state_d = ST_ABORT;
          end
        end
      end

      ST_WR_DATA: begin
        oEnable  = 1'b1;
        oWrite   = 1'b1;
        oAddr    = ADDR_TXD;
        oBusData = {8'h00, byte_q};
        state_d  = ST_WR_CTRL;
      end

      ST_WR_CTRL: begin
        oEnable  = 1'b1;
        oWrite   = 1'b1;
        oAddr    = ADDR_CTRL;
        oBusData = ctrl_word(1'b1, cfg_q);
        state_d  = ST_SETTLE;
      end

      ST_SETTLE: begin
        // One quiet cycle lets the UART register the send request before
        // the first poll; restart the timeout for the poll phase.
        cnt_d   = '0;
        state_d = ST_POLL;
      end

      ST_ABORT: begin
        oEnable  = 1'b1;
        oWrite   = 1'b1;
        oAddr    = ADDR_CTRL;
        oBusData = ctrl_word(1'b0, cfg_q);
        err_d    = 1'b1;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        ptr_d   = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + IDX_W'(1);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transfer in flight
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      byte_q  <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      byte_q  <= byte_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oBusy = (state_q != ST_IDLE);

  // Completion pulses: exactly one of ack/err, only in ST_DONE
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pulse
      assign oReqAck[gi] = (state_q == ST_DONE) && !err_q && (gidx_q == IDX_W'(gi));
      assign oReqErr[gi] = (state_q == ST_DONE) &&  err_q && (gidx_q == IDX_W'(gi));
    end
  endgenerate

endmodule
